// File: rtl/operand_sequencer_if.sv
// Operand bus between the strobe-driven front end and the operand sequencer.
// master drives operand data and control strobes; slave presents operands and status.
interface operand_sequencer_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             strobe;
    logic             clear;
    logic             ack;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             valid;
    logic [1:0]       state;

    modport master (
        output din, strobe, clear, ack,
        input  a, b, valid, state
    );

    modport slave (
        input  din, strobe, clear, ack,
        output a, b, valid, state
    );
endinterface

// File: rtl/operand_sequencer.sv
// Captures operand A then B on synchronised strobe rising edges and holds them valid until ack.
// Optional strobe debounce filter: define OPERAND_SEQUENCER_DEBOUNCE_EN.
module operand_sequencer #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input logic                clk,
    input logic                rst_n,
    operand_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HAVE_A = 2'b01,
        READY  = 2'b10
    } state_t;

    if (SYNC_STAGES < 2) begin : g_sync_check
        $error("SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_debounce_check
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] strobe_sync;
    logic [SYNC_STAGES-1:0] clear_sync;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   strobe_synced;
    logic                   clear_synced;
    logic                   ack_synced;
    logic                   strobe_filt;
    logic                   strobe_prev;
    logic                   strobe_rise;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             valid_q, valid_d;

    // Synchronisers preset high so a strobe held through reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_sync <= '1;
            clear_sync  <= '1;
            ack_sync    <= '1;
        end else begin
            strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], bus.strobe};
            clear_sync  <= {clear_sync[SYNC_STAGES-2:0], bus.clear};
            ack_sync    <= {ack_sync[SYNC_STAGES-2:0], bus.ack};
        end
    end

    assign strobe_synced = strobe_sync[SYNC_STAGES-1];
    assign clear_synced  = clear_sync[SYNC_STAGES-1];
    assign ack_synced    = ack_sync[SYNC_STAGES-1];

`ifdef OPERAND_SEQUENCER_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] db_cnt;

    // Filter output follows only after DEBOUNCE_CYCLES consecutive clocks at the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_filt <= 1'b1;
            db_cnt      <= '0;
        end else if (strobe_synced == strobe_filt) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            strobe_filt <= strobe_synced;
            db_cnt      <= '0;
        end else begin
            db_cnt <= db_cnt + CNT_W'(1);
        end
    end
`else
    assign strobe_filt = strobe_synced;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_prev <= 1'b1;
        end else begin
            strobe_prev <= strobe_filt;
        end
    end

    assign strobe_rise = strobe_filt & ~strobe_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
        end
    end

    // Priority: clear, then ack, then strobe edge; edges seen in READY are dropped.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        if (clear_synced) begin
            state_d = IDLE;
            a_d     = '0;
            b_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (strobe_rise) begin
                        a_d     = bus.din;
                        b_d     = '0;
                        state_d = HAVE_A;
                    end
                end
                HAVE_A: begin
                    if (strobe_rise) begin
                        b_d     = bus.din;
                        state_d = READY;
                    end
                end
                READY: begin
                    if (ack_synced) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        valid_d = (state_d == READY);
    end

    assign bus.a     = a_q;
    assign bus.b     = b_q;
    assign bus.valid = valid_q;
    assign bus.state = state_q;

endmodule

// File: doc/operand_sequencer.md
Name: operand_sequencer

Overview:
- Upstream feeder for the 4-bit adder stage.
- Captures two operand nibbles, A then B, from a shared input bus. Each capture happens on a rising edge of a user strobe (push-button / pin), which is synchronised and edge-detected.
- Once both are held, presents A and B to the adder with a valid flag until the consumer acknowledges.
- Also exports its state for status LEDs on the top-level output pins.

Parameters:
- WIDTH, 4, operand width in bits (matches adder operand width).
- SYNC_STAGES, 2, synchroniser flops on strobe, clear and ack (minimum 2).
- DEBOUNCE_CYCLES, 16, stable-cycle count for the debounce filter (used only when the optional feature is compiled in; minimum 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  operand data bus; must be stable from strobe rise until capture.
- strobe  input  1  asynchronous capture request; rising edge captures din.
- clear  input  1  asynchronous abort; level-sensitive after synchronisation.
- ack  input  1  consumer acknowledge; level-sensitive after synchronisation.
- a  output  WIDTH  operand A to adder.
- b  output  WIDTH  operand B to adder.
- valid  output  1  a and b are complete and stable.
- state  output  2  encoded FSM state for LEDs.

Behaviour:
- Reset (rst_n low, asynchronous):
  - a=0, b=0, valid=0, state=IDLE.
  - All synchroniser and edge-history flops load 1. A strobe held high through reset release therefore produces no capture.
- Synchronisation: strobe, clear and ack each pass through SYNC_STAGES flops. edge = synced strobe & ~previous synced strobe.
- Capture latency: din is captured on the clock edge where edge is asserted, SYNC_STAGES+1 clocks after the first clk edge that samples strobe high. a/b update on that same edge.
- FSM states and encoding:
  - IDLE=2'b00
  - HAVE_A=2'b01
  - READY=2'b10
  - 2'b11 is unused and recovers to IDLE on the next clock.
- Transitions:
  - IDLE: edge -> a<=din, b<=0, go HAVE_A.
  - HAVE_A: edge -> b<=din, go READY; valid rises the same edge.
  - READY: valid=1; a, b frozen. Synced ack=1 -> valid<=0, go IDLE. a and b keep their values until the next capture.
- valid is registered; valid=1 exactly when state=READY.
- Priority within a cycle: clear > ack > edge.
  - Synced clear=1 in any state -> state IDLE, valid 0, a and b cleared to 0.
  - Edge in READY is ignored and lost, including a simultaneous edge and ack.
  - ack outside READY is ignored.
  - ack held high across several cycles causes only one release. The FSM does not re-enter READY without two fresh strobe edges.
- Repeated strobe within a state: only one capture per rising edge. Strobe held high does not re-capture.
- Reset mid-operation: immediate return to reset values regardless of state. Partially loaded operands are discarded.
- No arithmetic in this block; widths pass through unchanged.

Optional Feature:
- Macro: OPERAND_SEQUENCER_DEBOUNCE_EN.
- Defined:
  - A debounce filter sits between the strobe synchroniser and the edge detector.
  - The filtered strobe changes only after the synced strobe has held a new level for DEBOUNCE_CYCLES consecutive clocks. Any change restarts the counter.
  - Filter state resets to 1 and its counter to 0.
  - Capture latency becomes SYNC_STAGES+DEBOUNCE_CYCLES+1 clocks.
  - Bounces shorter than DEBOUNCE_CYCLES produce no capture.
- Undefined: no filter; the synced strobe feeds the edge detector directly. Behaviour is as above, with the filter counter absent from the netlist.

Test Plan:
- Reset, then strobe low: a=0, b=0, valid=0, state=00. Strobe held high through rst_n release -> still state=00 after 10 clocks.
- din=4'h3, pulse strobe; then din=4'hA, pulse strobe:
  - a=3 at SYNC_STAGES+1 clocks after the first strobe; state=01.
  - After the second strobe, b=A, valid=1, state=10.
  - Hold ack=1 -> valid=0 and state=00 SYNC_STAGES+1 clocks later; a=3, b=A retained.
- In READY, pulse strobe with din=4'hF, ack low: a, b unchanged, valid stays 1. Then assert ack together with a strobe: release to IDLE with no capture.
- Load A=5, assert clear in HAVE_A: state=00, a=0, b=0. Repeat with clear in READY: valid drops.
- Assert rst_n low mid-load (state=01, a=7): all outputs zero asynchronously, before the next clk edge.
- With OPERAND_SEQUENCER_DEBOUNCE_EN and DEBOUNCE_CYCLES=16:
  - A strobe glitch of 5 clocks -> no capture.
  - A strobe clean for 20 clocks -> a captured at SYNC_STAGES+17 clocks.
